gcd_datapath: RTL and testbench

GCD_DATAPATH -- requirements
Module: gcd_datapath

---
 rtl/gcd_pkg.sv | 12 +
 rtl/gcd_datapath_cells.sv | 27 ++
 rtl/gcd_datapath_reg_load.sv | 25 ++
 rtl/gcd_datapath.sv | 147 ++++++++++++++
 tb/tb_gcd_datapath.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD datapath: the operand width and the controller state type.
package gcd_pkg;

    localparam int unsigned WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage : gcd_pkg

// File: rtl/gcd_datapath_cells.sv
// Pre-existing library cells: the 8-bit 2-to-1 mux and the 8-bit bitwise OR gate.
module mux2_8 (
    input  logic       i_sel,
    input  logic [7:0] i_d0,
    input  logic [7:0] i_d1,
    output logic [7:0] o_y
);

    // Select d1 when sel is high, otherwise d0.
    always_comb begin
        o_y = i_sel ? i_d1 : i_d0;
    end

endmodule : mux2_8

module or_gate_8 (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic [7:0] o_y
);

    // Bitwise OR of the two inputs.
    always_comb begin
        o_y = i_a | i_b;
    end

endmodule : or_gate_8

// File: rtl/gcd_datapath_reg_load.sv
// Load-enabled register with asynchronous active-high clear.
module reg_load #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Capture the input when load is asserted; clear on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : reg_load

// File: rtl/gcd_datapath.sv
// Subtractive GCD engine: controller FSM plus A/B/result datapath built from library cells.
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = gcd_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy
);

    state_t r_state;
    state_t w_state_next;

    logic             w_sel;
    logic             w_ld_a;
    logic             w_ld_b;
    logic             w_ld_res;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_a_minus_b;
    logic [WIDTH-1:0] w_b_minus_a;
    logic [WIDTH-1:0] w_a_d;
    logic [WIDTH-1:0] w_b_d;
    logic [WIDTH-1:0] w_or;
    logic [WIDTH-1:0] w_res_d;
    logic             w_a_zero;
    logic             w_b_zero;
    logic             w_a_eq_b;
    logic             w_a_gt_b;

    // Comparator and the two candidate differences; only the larger-minus-smaller one is loaded.
    always_comb begin
        w_a_zero    = (w_a == '0);
        w_b_zero    = (w_b == '0);
        w_a_eq_b    = (w_a == w_b);
        w_a_gt_b    = (w_a > w_b);
        w_a_minus_b = w_a - w_b;
        w_b_minus_a = w_b - w_a;
    end

    // Operand muxes: select=1 takes the new operand, select=0 takes the difference.
    mux2_8 u_mux_a (
        .i_sel (w_sel),
        .i_d0  (w_a_minus_b),
        .i_d1  (a_in),
        .o_y   (w_a_d)
    );

    mux2_8 u_mux_b (
        .i_sel (w_sel),
        .i_d0  (w_b_minus_a),
        .i_d1  (b_in),
        .o_y   (w_b_d)
    );

    // A|B yields the nonzero operand when the other is zero.
    or_gate_8 u_or (
        .i_a (w_a),
        .i_b (w_b),
        .o_y (w_or)
    );

    // Result source: OR output for a zero operand, otherwise A (equal operands).
    always_comb begin
        w_res_d = (w_a_zero || w_b_zero) ? w_or : w_a;
    end

    reg_load #(.WIDTH(WIDTH)) u_reg_a (
        .clk    (clk),
        .rst    (reset),
        .i_load (w_ld_a),
        .i_d    (w_a_d),
        .o_q    (w_a)
    );

    reg_load #(.WIDTH(WIDTH)) u_reg_b (
        .clk    (clk),
        .rst    (reset),
        .i_load (w_ld_b),
        .i_d    (w_b_d),
        .o_q    (w_b)
    );

    reg_load #(.WIDTH(WIDTH)) u_reg_res (
        .clk    (clk),
        .rst    (reset),
        .i_load (w_ld_res),
        .i_d    (w_res_d),
        .o_q    (result)
    );

    // Controller state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, register load enables and status outputs.
    always_comb begin
        w_state_next = r_state;
        w_sel        = 1'b0;
        w_ld_a       = 1'b0;
        w_ld_b       = 1'b0;
        w_ld_res     = 1'b0;
        done         = 1'b0;
        busy         = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_sel        = 1'b1;
                    w_ld_a       = 1'b1;
                    w_ld_b       = 1'b1;
                    w_state_next = COMPARE;
                end
            end
            COMPARE: begin
                busy = 1'b1;
                if (w_a_zero || w_b_zero || w_a_eq_b) begin
                    w_ld_res     = 1'b1;
                    w_state_next = DONE;
                end else if (w_a_gt_b) begin
                    w_ld_a = 1'b1;
                end else begin
                    w_ld_b = 1'b1;
                end
            end
            DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule : gcd_datapath

// File: tb/tb_gcd_datapath.sv
// Scoreboard bench for gcd_datapath: expected results queued at acceptance, checked at done.
module tb_gcd_datapath;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic [7:0] result;
    logic       done;
    logic       busy;

    int n_vec;
    int n_bad;
    logic [7:0] exp_q[$];

    gcd_datapath #(.WIDTH(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .result (result),
        .done   (done),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Euclid by remainder, independent of the subtractive hardware algorithm.
    function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Edges from acceptance until done is visible: subtraction count plus the final compare.
    function automatic int ref_lat(input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        while (a != 0 && b != 0 && a != b) begin
            if (a > b) a = a - b;
            else       b = b - a;
            n++;
        end
        return n + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for done with a cycle budget; returns edges counted.
    task automatic wait_done(output int cnt);
        cnt = 0;
        while (!done && cnt < 1000) begin
            tick();
            cnt++;
        end
    endtask

    task automatic pop_check(input string tag);
        if (exp_q.size() > 0) check(tag, result, exp_q.pop_front());
        else                  check({tag, "_sb_empty"}, 1, 0);
    endtask

    // Full operation: accept, optionally scramble inputs, wait, check latency/result/status.
    task automatic op(input logic [7:0] a, input logic [7:0] b, input bit scramble);
        int cnt;
        int lat;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        exp_q.push_back(ref_gcd(a, b));
        lat = ref_lat(a, b);
        tick();
        start = 1'b0;
        if (scramble) begin
            a_in = 8'($urandom);
            b_in = 8'($urandom);
        end
        check("busy_accept", busy, 1);
        wait_done(cnt);
        check("latency", cnt, lat);
        check("done", done, 1);
        check("busy_done", busy, 1);
        pop_check("result");
        tick();
        check("done_fall", done, 0);
        check("busy_idle", busy, 0);
        check("result_hold", result, ref_gcd(a, b));
    endtask

    initial begin
        int cnt;
        int pulses;
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        #3;
        check("rst_result", result, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Idle with start low: nothing happens.
        tick();
        check("idle_busy", busy, 0);

        op(8'd12, 8'd8, 1'b0);
        op(8'd255, 8'd1, 1'b0);
        op(8'd0, 8'd9, 1'b0);
        op(8'd0, 8'd0, 1'b0);
        op(8'd9, 8'd0, 1'b0);
        op(8'd21, 8'd21, 1'b0);
        op(8'd1, 8'd255, 1'b1);
        for (int unsigned i = 0; i < 6; i++) begin
            op(8'($urandom), 8'($urandom), 1'b1);
        end

        // Start while busy is ignored; no second operation follows.
        a_in  = 8'd12;
        b_in  = 8'd8;
        start = 1'b1;
        exp_q.push_back(8'd4);
        tick();
        a_in = 8'd5;
        b_in = 8'd3;
        tick();
        start = 1'b0;
        wait_done(cnt);
        check("busy_start_done", done, 1);
        pop_check("busy_start_result");
        pulses = 0;
        for (int unsigned i = 0; i < 12; i++) begin
            tick();
            if (done || busy) pulses++;
        end
        check("no_second_op", pulses, 0);

        // Start held through DONE: one idle cycle, then re-accept with current inputs.
        a_in  = 8'd6;
        b_in  = 8'd4;
        start = 1'b1;
        exp_q.push_back(8'd2);
        tick();
        a_in = 8'd9;
        b_in = 8'd6;
        wait_done(cnt);
        check("held_latency", cnt, 3);
        pop_check("held_result");
        tick();
        check("held_idle_busy", busy, 0);
        exp_q.push_back(8'd3);
        tick();
        start = 1'b0;
        check("held_reaccept_busy", busy, 1);
        wait_done(cnt);
        check("held2_latency", cnt, 3);
        pop_check("held2_result");
        tick();

        // Reset in the middle of 255/1.
        a_in  = 8'd255;
        b_in  = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        pulses = 0;
        for (int unsigned i = 0; i < 99; i++) begin
            tick();
            if (done) pulses++;
        end
        check("pre_reset_no_done", pulses, 0);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_result", result, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_busy", busy, 0);
        tick();
        reset = 1'b0;
        pulses = 0;
        for (int unsigned i = 0; i < 5; i++) begin
            tick();
            if (done || busy) pulses++;
        end
        check("post_rst_quiet", pulses, 0);
        op(8'd6, 8'd4, 1'b1);

        check("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_gcd_datapath
